// File: rtl/shift_pkg.sv
// Shared definitions for the sequential right shifter: FSM encoding and default sizes.
package shift_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_right_step.sv
// Combinational single-bit right shift; the vacated MSB takes the fill bit.
module shift_right_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] in,
    input  logic             fill,
    output logic [WIDTH-1:0] out
);

    assign out = {fill, in[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_seq.sv
// Iterative right shifter: captures an operand on start, shifts one bit per clock,
// and publishes the result on out with a one-cycle done pulse.
module shift_right_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] n,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam logic [CNT_W-1:0] CntZero = '0;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] shifted;

    shift_right_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .in   (work_q),
        .fill (fill_q),
        .out  (shifted)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        count_d = count_q;
        fill_d  = fill_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = in;
                    fill_d  = arith & in[WIDTH-1];
                    count_d = n;
                    if (n == CntZero) begin
                        out_d   = in;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // count is always >= 1 here, so the decrement cannot wrap
                work_d  = shifted;
                count_d = count_q - CntOne;
                if (count_q == CntOne) begin
                    out_d   = shifted;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            out_q   <= '0;
            count_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            count_q <= count_d;
            fill_q  <= fill_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign out  = out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: hand-computed results, latency, handshake and reset.
module tb_shift_right_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] in_v;
    logic [1:0] n_v;
    logic       arith;
    logic       busy;
    logic       done;
    logic [3:0] out;

    int vectors;
    int miscompares;

    shift_right_seq #(
        .WIDTH (4),
        .CNT_W (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in_v),
        .n     (n_v),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and follow it through to the cycle after done.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [1:0] sh,
                          input logic ar, input logic [3:0] exp);
        logic [3:0] prev;
        int         edges;
        in_v  = a;
        n_v   = sh;
        arith = ar;
        start = 1'b1;
        prev  = out;
        step();
        start = 1'b0;
        edges = 1;
        check_eq({tag, "_busy"}, 32'(busy), 32'(1));
        while (!done && edges < 12) begin
            check_eq({tag, "_hold"}, 32'(out), 32'(prev));
            step();
            edges++;
        end
        check_eq({tag, "_lat"}, 32'(edges), 32'(sh) + 32'd1);
        check_eq({tag, "_done"}, 32'(done), 32'(1));
        check_eq({tag, "_out"}, 32'(out), 32'(exp));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'(1));
        step();
        check_eq({tag, "_done_off"}, 32'(done), 32'(0));
        check_eq({tag, "_idle"}, 32'(busy), 32'(0));
        check_eq({tag, "_out_hold"}, 32'(out), 32'(exp));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        in_v  = 4'b0000;
        n_v   = 2'd0;
        arith = 1'b0;
        #2;
        check_eq("rst_out", 32'(out), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        step();
        step();
        check_eq("idle_done", 32'(done), 32'(0));

        run_op("lsr1", 4'b1100, 2'd1, 1'b0, 4'b0110);
        run_op("lsr3", 4'b1100, 2'd3, 1'b0, 4'b0001);
        run_op("lsr2", 4'b1100, 2'd2, 1'b0, 4'b0011);
        run_op("asr3", 4'b1100, 2'd3, 1'b1, 4'b1111);
        run_op("asr2", 4'b0110, 2'd2, 1'b1, 4'b0001);
        run_op("n0", 4'b1010, 2'd0, 1'b0, 4'b1010);

        // start held high: accepted in IDLE, ignored in DONE, next op taken back in IDLE
        in_v  = 4'b1010;
        n_v   = 2'd0;
        arith = 1'b0;
        start = 1'b1;
        step();
        in_v = 4'b0101;
        n_v  = 2'd1;
        check_eq("b2b_done1", 32'(done), 32'(1));
        check_eq("b2b_out1", 32'(out), 32'(4'b1010));
        step();
        check_eq("b2b_gap_done", 32'(done), 32'(0));
        check_eq("b2b_gap_busy", 32'(busy), 32'(0));
        step();
        start = 1'b0;
        check_eq("b2b_shift_busy", 32'(busy), 32'(1));
        check_eq("b2b_shift_done", 32'(done), 32'(0));
        check_eq("b2b_shift_out", 32'(out), 32'(4'b1010));
        step();
        check_eq("b2b_done2", 32'(done), 32'(1));
        check_eq("b2b_out2", 32'(out), 32'(4'b0010));
        step();
        check_eq("b2b_done_off", 32'(done), 32'(0));

        // input changes and a start pulse while shifting must not disturb the operation
        in_v  = 4'b1000;
        n_v   = 2'd3;
        arith = 1'b0;
        start = 1'b1;
        step();
        in_v  = 4'b1111;
        n_v   = 2'd1;
        arith = 1'b1;
        step();
        start = 1'b0;
        check_eq("busychg_done_e2", 32'(done), 32'(0));
        step();
        check_eq("busychg_done_e3", 32'(done), 32'(0));
        step();
        check_eq("busychg_done", 32'(done), 32'(1));
        check_eq("busychg_out", 32'(out), 32'(4'b0001));
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("busychg_no_extra", 32'(done), 32'(0));
        end
        check_eq("busychg_out_hold", 32'(out), 32'(4'b0001));

        // asynchronous reset between edges during SHIFT
        in_v  = 4'b1100;
        n_v   = 2'd3;
        arith = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out", 32'(out), 32'(0));
        check_eq("arst_busy", 32'(busy), 32'(0));
        check_eq("arst_done", 32'(done), 32'(0));
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("arst_no_done", 32'(done), 32'(0));
            check_eq("arst_idle", 32'(busy), 32'(0));
        end
        run_op("post_rst", 4'b1001, 2'd1, 1'b1, 4'b1100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
